// File: rtl/switch_bcd_display.sv
// Multi-channel switch field to decimal seven-segment driver.
// Iterative double-dabble conversion, outputs refreshed once per sweep.
module switch_bcd_display #(
  parameter int CHANNELS = 2,
  parameter int IN_W     = 7,
  parameter int DIGITS   = 2,
  parameter int SAT_MAX  = 99
) (
  input  logic                         CLOCK_50,
  input  logic                         RESET_N,
  input  logic [CHANNELS*IN_W-1:0]     SW,
  input  logic                         BLANK_LZ,
  output logic [CHANNELS*DIGITS*7-1:0] HEX,
  output logic [CHANNELS-1:0]          OVF,
  output logic                         BUSY,
  output logic                         UPDATE
);

  localparam int SNW   = CHANNELS*IN_W + 1;
  localparam int BW    = 4*DIGITS;
  localparam int HW    = CHANNELS*DIGITS*7;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [31:0] SAT = 32'(SAT_MAX);

  if (10**DIGITS <= SAT_MAX) begin : g_bad_digits
    $error("DIGITS too small for SAT_MAX");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_STORE
  } state_t;

  state_t              state_q, state_d;
  logic [SNW-1:0]      sync1_q, sync1_d;
  logic [SNW-1:0]      sync2_q, sync2_d;
  logic [SNW-1:0]      snap_q, snap_d;
  logic                snap_vld_q, snap_vld_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IN_W-1:0]     bin_q, bin_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CHANNELS-1:0] ovf_tmp_q, ovf_tmp_d;
  logic [HW-1:0]       shadow_q, shadow_d;
  logic [HW-1:0]       hex_q, hex_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                update_q, update_d;

  logic [IN_W-1:0]     fld;
  logic [BW-1:0]       bcd_adj;
  logic [3:0]          dig;
  logic                zero_hi;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_comb begin
    sync1_d    = {SW, BLANK_LZ};
    sync2_d    = sync1_q;
    state_d    = state_q;
    snap_d     = snap_q;
    snap_vld_d = snap_vld_q;
    ch_d       = ch_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    ovf_tmp_d  = ovf_tmp_q;
    shadow_d   = shadow_q;
    hex_d      = hex_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    update_d   = 1'b0;
    fld        = snap_q[1 + int'(ch_q)*IN_W +: IN_W];
    bcd_adj    = bcd_q;
    dig        = 4'd0;
    zero_hi    = 1'b1;

    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (!snap_vld_q || (sync2_q != snap_q)) begin
          snap_d     = sync2_q;
          snap_vld_d = 1'b1;
          busy_d     = 1'b1;
          ch_d       = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (32'(fld) > SAT) begin
          bin_d           = SAT[IN_W-1:0];
          ovf_tmp_d[ch_q] = 1'b1;
        end else begin
          bin_d           = fld;
          ovf_tmp_d[ch_q] = 1'b0;
        end
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[BW-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(IN_W-1)) begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        // Walk from the top digit so zero_hi covers digits d..DIGITS-1
        for (int d = DIGITS-1; d >= 0; d--) begin
          dig     = bcd_q[4*d +: 4];
          zero_hi = zero_hi && (dig == 4'd0);
          if ((d > 0) && snap_q[0] && zero_hi) begin
            shadow_d[(int'(ch_q)*DIGITS + d)*7 +: 7] = 7'h7F;
          end else begin
            shadow_d[(int'(ch_q)*DIGITS + d)*7 +: 7] = seg7(dig);
          end
        end
        if (ch_q == CH_W'(CHANNELS-1)) begin
          hex_d    = shadow_d;
          ovf_d    = ovf_tmp_q;
          update_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    sync1_q <= sync1_d;
    sync2_q <= sync2_d;
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
      ch_q       <= '0;
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      ovf_tmp_q  <= '0;
      shadow_q   <= '1;
      hex_q      <= '1;
      ovf_q      <= '0;
      busy_q     <= 1'b0;
      update_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      ovf_tmp_q  <= ovf_tmp_d;
      shadow_q   <= shadow_d;
      hex_q      <= hex_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      update_q   <= update_d;
    end
  end

  assign HEX    = hex_q;
  assign OVF    = ovf_q;
  assign BUSY   = busy_q;
  assign UPDATE = update_q;

endmodule

// File: tb/tb_switch_bcd_display.sv
// Bench for switch_bcd_display: decimal reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_switch_bcd_display;

  localparam int CHANNELS = 2;
  localparam int IN_W     = 7;
  localparam int DIGITS   = 2;
  localparam int SAT_MAX  = 99;
  localparam int SWW      = CHANNELS*IN_W;
  localparam int HW       = CHANNELS*DIGITS*7;
  localparam int LAT      = CHANNELS*(IN_W+2);

  logic                CLOCK_50 = 1'b0;
  logic                RESET_N  = 1'b0;
  logic [SWW-1:0]      SW       = '0;
  logic                BLANK_LZ = 1'b0;
  logic [HW-1:0]       HEX;
  logic [CHANNELS-1:0] OVF;
  logic                BUSY;
  logic                UPDATE;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  switch_bcd_display #(
    .CHANNELS(CHANNELS),
    .IN_W(IN_W),
    .DIGITS(DIGITS),
    .SAT_MAX(SAT_MAX)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N(RESET_N),
    .SW(SW),
    .BLANK_LZ(BLANK_LZ),
    .HEX(HEX),
    .OVF(OVF),
    .BUSY(BUSY),
    .UPDATE(UPDATE)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic int field(input logic [SWW-1:0] sw, input int k);
    return int'((sw >> (k*IN_W)) & ((1 << IN_W) - 1));
  endfunction

  function automatic logic [HW-1:0] exp_hex(input logic [SWW-1:0] sw,
                                            input logic blz);
    logic [HW-1:0] r;
    int v, p, dg;
    r = '1;
    for (int k = 0; k < CHANNELS; k++) begin
      v = field(sw, k);
      if (v > SAT_MAX) v = SAT_MAX;
      p = 1;
      for (int d = 0; d < DIGITS; d++) begin
        dg = (v / p) % 10;
        if (d > 0 && blz && v < p) r[(k*DIGITS+d)*7 +: 7] = 7'h7F;
        else r[(k*DIGITS+d)*7 +: 7] = seg_tbl[dg];
        p = p * 10;
      end
    end
    return r;
  endfunction

  function automatic logic [CHANNELS-1:0] exp_ovf(input logic [SWW-1:0] sw);
    logic [CHANNELS-1:0] r;
    for (int k = 0; k < CHANNELS; k++) r[k] = field(sw, k) > SAT_MAX;
    return r;
  endfunction

  // Reference: two-edge input delay, snapshot, fixed-latency sweep
  logic [SWW:0]        m_s1, m_s2, m_snap;
  bit                  m_vld = 0, m_busy = 0, m_upd = 0;
  int                  m_cnt = 0;
  logic [HW-1:0]       m_hex = '1;
  logic [CHANNELS-1:0] m_ovf = '0;

  always @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      m_vld  = 0;
      m_busy = 0;
      m_upd  = 0;
      m_cnt  = 0;
      m_hex  = '1;
      m_ovf  = '0;
    end else begin
      m_upd = 0;
      if (!m_busy) begin
        if (!m_vld || m_s2 !== m_snap) begin
          m_snap = m_s2;
          m_vld  = 1;
          m_busy = 1;
          m_cnt  = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == LAT) begin
          m_hex  = exp_hex(m_snap[SWW:1], m_snap[0]);
          m_ovf  = exp_ovf(m_snap[SWW:1]);
          m_upd  = 1;
          m_busy = 0;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = {SW, BLANK_LZ};
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40)
        $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (cmp_en) begin
      chk("model_hex", 64'(HEX), 64'(m_hex));
      chk("model_ovf", 64'(OVF), 64'(m_ovf));
      chk("model_busy", 64'(BUSY), 64'(m_busy));
      chk("model_update", 64'(UPDATE), 64'(m_upd));
    end
  end

  task automatic wait_update(input int bound);
    bit seen;
    seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge CLOCK_50);
      if (UPDATE === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL update_timeout at %0t: got no UPDATE expected one", $time);
    end
  endtask

  task automatic wait_busy(input int bound);
    bit seen;
    seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge CLOCK_50);
      if (BUSY === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL busy_timeout at %0t: got no BUSY expected one", $time);
    end
  endtask

  task automatic set_sw(input int hi, input int lo, input logic b);
    logic [IN_W-1:0] h, l;
    h = IN_W'(hi);
    l = IN_W'(lo);
    SW       = {h, l};
    BLANK_LZ = b;
  endtask

  logic [HW-1:0] e;
  int lat;

  initial begin
    RESET_N = 1'b0;
    set_sw(0, 0, 1'b0);
    @(posedge CLOCK_50);
    cmp_en = 1;
    repeat (3) @(negedge CLOCK_50);
    chk("reset_hex", 64'(HEX), 64'(28'hFFFFFFF));
    chk("reset_busy", 64'(BUSY), 64'd0);

    RESET_N = 1'b1;
    wait_busy(10);
    lat = 0;
    while (UPDATE !== 1'b1 && lat < 60) begin
      @(negedge CLOCK_50);
      lat++;
    end
    chk("sweep_latency", 64'(lat), 64'(LAT));
    e = {7'h40, 7'h40, 7'h40, 7'h40};
    chk("zero_hex", 64'(HEX), 64'(e));
    chk("zero_ovf", 64'(OVF), 64'd0);

    set_sw(57, 8, 1'b0);
    wait_update(60);
    e = {7'h12, 7'h78, 7'h40, 7'h00};
    chk("d57_8_hex", 64'(HEX), 64'(e));
    chk("d57_8_ovf", 64'(OVF), 64'd0);

    set_sw(127, 100, 1'b0);
    wait_update(60);
    e = {7'h10, 7'h10, 7'h10, 7'h10};
    chk("sat_hex", 64'(HEX), 64'(e));
    chk("sat_ovf", 64'(OVF), 64'd3);

    set_sw(57, 8, 1'b0);
    wait_update(60);
    set_sw(57, 8, 1'b1);
    wait_update(60);
    e = {7'h12, 7'h78, 7'h7F, 7'h00};
    chk("blank_hex", 64'(HEX), 64'(e));

    set_sw(3, 42, 1'b0);
    wait_busy(10);
    repeat (4) @(negedge CLOCK_50);
    set_sw(99, 0, 1'b0);
    wait_update(60);
    e = {7'h40, 7'h30, 7'h19, 7'h24};
    chk("old_snap_hex", 64'(HEX), 64'(e));
    wait_update(60);
    e = {7'h10, 7'h10, 7'h40, 7'h40};
    chk("new_snap_hex", 64'(HEX), 64'(e));

    set_sw(21, 64, 1'b0);
    wait_busy(10);
    repeat (12) @(negedge CLOCK_50);
    RESET_N = 1'b0;
    @(negedge CLOCK_50);
    chk("abort_hex", 64'(HEX), 64'(28'hFFFFFFF));
    chk("abort_ovf", 64'(OVF), 64'd0);
    chk("abort_busy", 64'(BUSY), 64'd0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    wait_update(60);
    e = {7'h24, 7'h79, 7'h02, 7'h19};
    chk("after_abort_hex", 64'(HEX), 64'(e));

    for (int it = 0; it < 60; it++) begin
      SW       = SWW'($urandom);
      BLANK_LZ = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        RESET_N = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge CLOCK_50);
        RESET_N = 1'b1;
      end
      repeat ($urandom_range(1, 30)) @(negedge CLOCK_50);
    end
    repeat (3*LAT) @(negedge CLOCK_50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
